// File: rtl/pending_req_collector.sv
// Collects request pulses into pend_vec and offers a snapshot to the MSB decoder: req -> snap_valid in 2 cycles.
// The snapshot is held until snap_ready. PRC_TIMEOUT_EN adds a bounded wait for the returned index.
module pending_req_collector #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4,
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_set,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_vec,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  output logic [WIDTH-1:0] pend_vec,
  output logic [7:0]       drop_cnt,
  output logic             idx_err,
  output logic             tmo_pulse
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load_snap;
  logic             idx_ok;
  logic             clr_fire;
  logic             tmo_expire;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] dup_hits;

  assign idx_ok   = int'(clr_idx) < WIDTH;
  assign clr_fire = (state == WAIT_CLR) && clr_valid && idx_ok;
  assign clr_mask = clr_fire ? (WIDTH'(1) << clr_idx) : '0;
  // A set landing on a bit being cleared is not a duplicate: the clear consumed the old request.
  assign dup_hits = req_set & pend_vec & ~clr_mask;

  assign snap_valid = (state == OFFER);

`ifdef PRC_TIMEOUT_EN
  localparam int CNT_W = (TMO > 2) ? $clog2(TMO) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_expire = (state == WAIT_CLR) && !clr_valid && (tmo_cnt == CNT_W'(TMO - 1));
  assign tmo_pulse  = tmo_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state != WAIT_CLR) || clr_valid || tmo_expire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_expire = 1'b0;
  assign tmo_pulse  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    idx_err   = 1'b0;
    case (state)
      IDLE: begin
        if (|pend_vec) begin
          load_snap = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (snap_ready) begin
          state_nxt = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (clr_valid) begin
          idx_err   = !idx_ok;
          state_nxt = IDLE;
        end else if (tmo_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      snap_vec <= '0;
      pend_vec <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pend_vec <= (pend_vec & ~clr_mask) | req_set;
      if (load_snap) begin
        snap_vec <= pend_vec;
      end
      if ((|dup_hits) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
